dual_rail_wavefront_tx: RTL and testbench

- Clocked transmitter that turns single-rail words into dual-rail NCL wavefronts (DATA, NULL, DATA, ...) for the asynchronous datapath, e.g. the PH0/MI inputs of the memory R/W mux.
- Paces each wavefront on the completion signal (ko) returned by the downstream NCL stage, so a DATA/NULL change is issued only when the stage requests it.
- Sits at the boundary between the synchronous stimulus/control domain and the NCL logic, in front of the NCL blocks.
- Adds ko synchronisation, a stall timeout with a sticky error, and a count of completed wavefronts.

---
 rtl/dual_rail_wavefront_tx.sv | 63 ++++++
 tb/tb_dual_rail_wavefront_tx.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/dual_rail_wavefront_tx.sv
// dual_rail_wavefront_tx: paces single-rail words onto a dual-rail NCL bus as DATA/NULL wavefronts gated by downstream ko
module dual_rail_wavefront_tx #(
  parameter int WIDTH       = 2,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] dr_t,
  output logic [WIDTH-1:0] dr_f,
  input  logic             ko_i,
  input  logic             err_clr,
  output logic             busy,
  output logic             timeout_err,
  output logic [15:0]      wave_count
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef enum logic [2:0] {S_WAIT, S_IDLE, S_DATA, S_NULL, S_ERR} state_t;
  state_t state, nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt;
  logic ko_s, waiting, expire;
  assign ko_s    = sync[SYNC_STAGES-1];
  assign waiting = state inside {S_WAIT, S_DATA, S_NULL};
  assign expire  = TIMEOUT != 0 && waiting && cnt == CW'(TIMEOUT - 1);
  always_comb begin
    nxt = state;
    case (state)
      S_WAIT:  nxt = ko_s ? S_IDLE : expire ? S_ERR : S_WAIT;
      S_IDLE:  nxt = in_valid ? S_DATA : S_IDLE;
      S_DATA:  nxt = !ko_s ? S_NULL : expire ? S_ERR : S_DATA;
      S_NULL:  nxt = ko_s ? S_IDLE : expire ? S_ERR : S_NULL;
      S_ERR:   nxt = err_clr ? S_WAIT : S_ERR;
      default: nxt = S_WAIT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_WAIT;
      sync        <= '0;
      cnt         <= '0;
      dr_t        <= '0;
      dr_f        <= '0;
      in_ready    <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      wave_count  <= '0;
    end else begin
      state       <= nxt;
      sync        <= {sync[SYNC_STAGES-2:0], ko_i};
      cnt         <= nxt != state ? '0 : cnt + CW'(waiting);
      dr_t        <= nxt != S_DATA ? '0 : state == S_IDLE ? in_data : dr_t;
      dr_f        <= nxt != S_DATA ? '0 : state == S_IDLE ? ~in_data : dr_f;
      in_ready    <= nxt == S_IDLE;
      busy        <= nxt inside {S_DATA, S_NULL};
      timeout_err <= nxt == S_ERR;
      wave_count  <= wave_count + 16'(state == S_DATA && nxt == S_NULL);
    end
  end
endmodule

// File: tb/tb_dual_rail_wavefront_tx.sv
// tb_dual_rail_wavefront_tx: directed checks of wavefront pacing, timeout, reset and wrap
module tb_dual_rail_wavefront_tx;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, ko_i = 1'b1, err_clr = 1'b0;
  logic [1:0] in_data = 2'b00;
  logic in_ready, busy, timeout_err;
  logic [1:0] dr_t, dr_f;
  logic [15:0] wave_count;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  dual_rail_wavefront_tx #(.WIDTH(2), .SYNC_STAGES(2), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .dr_t(dr_t), .dr_f(dr_f), .ko_i(ko_i), .err_clr(err_clr), .busy(busy),
    .timeout_err(timeout_err), .wave_count(wave_count)
  );
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    chk("no_both_rails", 16'(dr_t & dr_f), 16'h0);
  endtask
  task automatic tick_n(input int n);
    repeat (n) tick();
  endtask
  task automatic send(input logic [1:0] w);
    logic [1:0] nw;
    nw = ~w;
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid = 1'b0;
    chk("data_t", dr_t, w);
    chk("data_f", dr_f, nw);
    chk("data_busy", busy, 1);
    chk("data_ready", in_ready, 0);
  endtask
  task automatic wave(input logic [1:0] w, input logic [15:0] wc);
    send(w);
    tick_n(3);
    chk("hold_t", dr_t, w);
    ko_i = 1'b0;
    tick_n(2);
    chk("still_data", dr_t, w);
    tick();
    chk("null_t", dr_t, 0);
    chk("null_f", dr_f, 0);
    chk("null_busy", busy, 1);
    chk("wave_count", wave_count, wc);
    ko_i = 1'b1;
    tick_n(2);
    chk("null_hold", dr_t | dr_f, 0);
    chk("null_ready", in_ready, 0);
    tick();
    chk("idle_ready", in_ready, 1);
    chk("idle_busy", busy, 0);
  endtask
  initial begin
    tick_n(3);
    chk("rst_t", dr_t, 0);
    chk("rst_f", dr_f, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", timeout_err, 0);
    chk("rst_count", wave_count, 0);
    rst_n = 1'b1;
    tick();
    chk("sync1_ready", in_ready, 0);
    tick();
    chk("sync2_ready", in_ready, 0);
    tick();
    chk("startup_ready", in_ready, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_ignored_ready", in_ready, 1);
    chk("clr_ignored_err", timeout_err, 0);
    wave(2'b10, 16'd1);
    wave(2'b01, 16'd2);
    wave(2'b11, 16'd3);
    wave(2'b00, 16'd4);
    send(2'b11);
    tick_n(15);
    chk("stall_pre_err", timeout_err, 0);
    chk("stall_pre_t", dr_t, 2'b11);
    tick();
    chk("stall_err", timeout_err, 1);
    chk("stall_ready", in_ready, 0);
    chk("stall_busy", busy, 0);
    chk("stall_bus", {dr_t, dr_f}, 0);
    chk("stall_count", wave_count, 4);
    tick_n(4);
    chk("err_sticky", timeout_err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_err", timeout_err, 0);
    chk("clr_wait_ready", in_ready, 0);
    tick();
    chk("clr_idle_ready", in_ready, 1);
    send(2'b10);
    tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_bus", {dr_t, dr_f}, 0);
    chk("midrst_count", wave_count, 0);
    chk("midrst_busy", busy, 0);
    rst_n = 1'b1;
    tick_n(3);
    chk("midrst_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data  = 2'b01;
    tick();
    chk("bp_cap_t", dr_t, 2'b01);
    in_data = 2'b10;
    tick();
    chk("bp_hold_t", dr_t, 2'b01);
    chk("bp_hold_f", dr_f, 2'b10);
    in_data = 2'b11;
    ko_i = 1'b0;
    tick_n(3);
    chk("bp_null", {dr_t, dr_f}, 0);
    chk("bp_count1", wave_count, 1);
    in_data = 2'b00;
    ko_i = 1'b1;
    tick_n(2);
    chk("bp_null_busy", busy, 1);
    chk("bp_null_bus", {dr_t, dr_f}, 0);
    tick();
    chk("bp_idle", in_ready, 1);
    in_data = 2'b10;
    tick();
    chk("bp_accept_t", dr_t, 2'b10);
    chk("bp_accept_f", dr_f, 2'b01);
    in_valid = 1'b0;
    in_data  = 2'b01;
    tick();
    chk("bp_after_t", dr_t, 2'b10);
    ko_i = 1'b0;
    tick_n(3);
    chk("bp_count2", wave_count, 2);
    ko_i = 1'b1;
    tick_n(3);
    chk("bp_end_ready", in_ready, 1);
    force dut.wave_count = 16'hFFFF;
    #1;
    release dut.wave_count;
    wave(2'b01, 16'h0000);
    send(2'b00);
    tick_n(13);
    ko_i = 1'b0;
    tick_n(2);
    chk("race_data_f", dr_f, 2'b11);
    chk("race_pre_err", timeout_err, 0);
    tick();
    chk("race_null", {dr_t, dr_f}, 0);
    chk("race_err", timeout_err, 0);
    chk("race_busy", busy, 1);
    chk("race_count", wave_count, 1);
    ko_i = 1'b1;
    tick_n(3);
    chk("race_idle", in_ready, 1);
    chk("race_end_err", timeout_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
